// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory arbiter.
//   state_t        - arbiter FSM states
//   owner_t        - which requester owns the current transaction (OWN_I fetch, OWN_D data)
//   STARVE_MAX_DEF - default number of back-to-back data grants tolerated while a fetch waits
//   CNT_W          - width of the saturating starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_I = 2'd2,
    WAIT_D = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 3;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: requester selection for the memory arbiter.
// Data wins by default; fetch wins when it is the only requester, or when the
// data side has already taken STARVE_MAX consecutive grants past a waiting fetch.
//   if_req - fetch request pending
//   d_req  - data request pending
//   count  - consecutive data grants while fetch was waiting
//   sel    - chosen owner (only meaningful when if_req | d_req)
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] count,
  output owner_t           sel
);

  logic starved;

  assign starved = (count == CNT_W'(STARVE_MAX));

  always_comb begin
    sel = OWN_D;
    if (if_req && (!d_req || starved)) sel = OWN_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (fetch / data) arbiter in front of a single memory port,
// at most one transaction outstanding.
//   clk, rst                          - clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt          - fetch request and acceptance strobe
//   if_rvalid/if_rdata                - fetch response (same cycle as m_rvalid)
//   d_req/d_we/d_addr/d_wdata/d_wstrb - data request
//   d_gnt, d_rvalid/d_rdata           - data acceptance, response or write ack
//   m_req/m_we/m_addr/m_wdata/m_wstrb - memory request, held until m_ready
//   m_ready                           - memory accepts m_req this cycle
//   m_rvalid/m_rdata                  - memory response, one per accepted request
//   err                               - sticky: a response arrived with nothing outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wstrb,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wstrb,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata,
  output logic          err
);

  state_t           state_q, state_d;
  owner_t           own_q, sel;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             any_req;
  logic             take;

  assign any_req = if_req | d_req;
  assign take    = (state_q == IDLE) && any_req;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .if_req (if_req),
    .d_req  (d_req),
    .count  (cnt_q),
    .sel    (sel)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Response with nothing outstanding (includes a late one after reset).
      if (m_rvalid && (state_q == IDLE || state_q == ISSUE)) err_q <= 1'b1;
    end
  end

  // NOTE: the latched request fields carry no reset; every output they feed is
  // qualified by the ISSUE state, so their power-up contents are never visible.
  always_ff @(posedge clk) begin
    if (take) begin
      own_q <= sel;
      if (sel == OWN_D) begin
        we_q    <= d_we;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        wstrb_q <= d_wstrb;
      end else begin
        we_q    <= 1'b0;
        addr_q  <= if_addr;
        wdata_q <= '0;
        wstrb_q <= '0;
      end
    end
  end

  // Starvation counter: only counts data selections made past a waiting fetch.
  always_comb begin
    cnt_d = cnt_q;
    if (take) begin
      if (sel == OWN_I || !if_req) cnt_d = '0;
      else if (cnt_q != '1)        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    err       = err_q & ~rst;

    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        m_req   = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_wstrb = wstrb_q;
        if (m_ready) begin
          if_gnt  = (own_q == OWN_I);
          d_gnt   = (own_q == OWN_D);
          state_d = (own_q == OWN_I) ? WAIT_I : WAIT_D;
        end
      end
      WAIT_I: begin
        if (m_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = m_rdata;
          state_d   = IDLE;
        end
      end
      WAIT_D: begin
        if (m_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs sit at their reset values for the whole time rst is high.
    if (rst) begin
      m_req     = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_wstrb   = '0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
    end
  end

endmodule
